// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the decode/issue control slice:
//   - XLEN_DEFAULT       : default instruction / PC width
//   - OPC_*              : RV32 major opcodes relevant to load-use detection
//   - state_e            : issue controller state (RUN / STALL / FLUSH)
//   - load_use_hazard()  : operand-match rule between the decode head and a
//                          load sitting in execute
// -----------------------------------------------------------------------------
package decode_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // LUI/AUIPC/JAL carry immediate bits in the rs1 field, so they never read
  // rs1. Only R-type, stores and branches actually read rs2.
  function automatic logic load_use_hazard(input logic [6:0] opcode,
                                           input logic [4:0] rs1,
                                           input logic [4:0] rs2,
                                           input logic       ex_is_load,
                                           input logic [4:0] ex_rd);
    logic uses_rs1;
    logic uses_rs2;
    uses_rs1 = !(opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    uses_rs2 = (opcode inside {OPC_OP, OPC_STORE, OPC_BRANCH});
    return ex_is_load && (ex_rd != 5'd0) &&
           ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// -----------------------------------------------------------------------------
// instr_fifo
// Small synchronous FIFO holding fetched {pc, instr} pairs.
// Parameters:
//   DEPTH : number of entries (power of two, >= 2)
//   WIDTH : entry width
// Ports:
//   clk, rstn       : clock, asynchronous active-low reset
//   clr             : synchronous clear (drops all entries)
//   push, wdata     : write one entry (ignored when full)
//   pop             : retire the head entry (ignored when empty)
//   rdata           : head entry (undefined content while empty)
//   empty, full     : occupancy flags
// Storage is not reset; only pointers and occupancy are.
// -----------------------------------------------------------------------------
module instr_fifo
  import decode_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2 * XLEN_DEFAULT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointer increments wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/decode_issue_ctrl.sv
// -----------------------------------------------------------------------------
// decode_issue_ctrl
// Buffers fetched instructions and issues them in order to the decoder,
// holding the head while it depends on a load currently in execute, and
// discarding all buffered work on a redirect.
// Parameters:
//   XLEN  : instruction / PC width
//   DEPTH : instruction buffer entries (power of two, >= 2)
// Ports:
//   clk, rstn                      : clock, asynchronous active-low reset
//   if_valid, if_instr, if_pc      : fetch beat in
//   if_ready                       : fetch beat accepted this cycle
//   dec_valid, dec_instr, dec_pc   : head instruction offered to decode
//   dec_ready                      : decode accepts the head
//   flush                          : redirect; empties buffer, one FLUSH cycle
//   ex_is_load, ex_rd              : load in execute and its destination
//   stall                          : head held by a load-use hazard
//   stall_cnt, flush_cnt           : saturating event counters
//                                    (only with DECODE_PERF_CNT_EN defined)
// Optional feature macro: DECODE_PERF_CNT_EN
// -----------------------------------------------------------------------------
module decode_issue_ctrl
  import decode_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_ready,
  output logic            dec_valid,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  input  logic            dec_ready,
  input  logic            flush,
  input  logic            ex_is_load,
  input  logic [4:0]      ex_rd,
  output logic            stall
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  state_e            state_q, state_d;
  logic [2*XLEN-1:0] fifo_wdata;
  logic [2*XLEN-1:0] fifo_rdata;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_push;
  logic              fifo_pop;
  logic [XLEN-1:0]   head_instr;
  logic [XLEN-1:0]   head_pc;
  logic              hazard;

  assign fifo_wdata = {if_pc, if_instr};
  assign head_instr = fifo_rdata[XLEN-1:0];
  assign head_pc    = fifo_rdata[2*XLEN-1:XLEN];

  assign hazard = !fifo_empty &&
                  load_use_hazard(head_instr[6:0], head_instr[19:15],
                                  head_instr[24:20], ex_is_load, ex_rd);

  // A flush cancels both same-cycle transfers. dec_valid requires a
  // non-empty buffer, so an empty buffer can never push and pop at once.
  assign fifo_push = if_valid && if_ready && !flush;
  assign fifo_pop  = dec_valid && dec_ready && !flush;

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (flush),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Next-state logic; flush overrides every state, including FLUSH itself.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_RUN:   state_d = hazard ? ST_STALL : ST_RUN;
        ST_STALL: state_d = hazard ? ST_STALL : ST_RUN;
        ST_FLUSH: state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  // Outputs. The head is gated to zero while empty so the decode bus reads
  // zero out of reset and never shows stale storage.
  always_comb begin
    if_ready  = 1'b0;
    dec_valid = 1'b0;
    stall     = 1'b0;
    dec_instr = '0;
    dec_pc    = '0;
    case (state_q)
      ST_RUN: begin
        if_ready  = !fifo_full;
        dec_valid = !fifo_empty && !hazard;
      end
      ST_STALL: begin
        if_ready = !fifo_full;
        stall    = 1'b1;
      end
      default: ;
    endcase
    if (!fifo_empty) begin
      dec_instr = head_instr;
      dec_pc    = head_pc;
    end
  end

`ifdef DECODE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  assign stall_cnt_d = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
  assign flush_cnt_d = flush ? sat_inc(flush_cnt_q) : flush_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_decode_issue_ctrl.sv
module tb_decode_issue_ctrl;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  localparam logic [6:0] T_OP = 7'h33, T_STORE = 7'h23, T_BRANCH = 7'h63;
  localparam logic [6:0] T_LUI = 7'h37, T_AUIPC = 7'h17, T_JAL = 7'h6F;
  localparam logic [6:0] T_OPIMM = 7'h13, T_LOAD = 7'h03;

  localparam int M_RUN = 0, M_STALL = 1, M_FLUSH = 2;

  logic            clk = 1'b0;
  logic            rstn = 1'b1;
  logic            if_valid = 1'b0;
  logic [XLEN-1:0] if_instr = '0;
  logic [XLEN-1:0] if_pc = '0;
  logic            if_ready;
  logic            dec_valid;
  logic [XLEN-1:0] dec_instr;
  logic [XLEN-1:0] dec_pc;
  logic            dec_ready = 1'b0;
  logic            flush = 1'b0;
  logic            ex_is_load = 1'b0;
  logic [4:0]      ex_rd = '0;
  logic            stall;
`ifdef DECODE_PERF_CNT_EN
  logic [31:0]     stall_cnt;
  logic [31:0]     flush_cnt;
`endif

  decode_issue_ctrl #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_ready   (if_ready),
    .dec_valid  (dec_valid),
    .dec_instr  (dec_instr),
    .dec_pc     (dec_pc),
    .dec_ready  (dec_ready),
    .flush      (flush),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .stall      (stall)
`ifdef DECODE_PERF_CNT_EN
    ,
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: queue of {pc, instr}, controller mode, event counts.
  logic [63:0] mq[$];
  int          mst = M_RUN;
  logic [31:0] m_stall_cnt = '0;
  logic [31:0] m_flush_cnt = '0;
  logic [31:0] next_pc = '0;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit ref_hazard(input logic [31:0] ins, input bit ld, input logic [4:0] rd);
    logic [6:0] op;
    bit reads1, reads2;
    op = ins[6:0];
    reads1 = !(op == T_LUI || op == T_AUIPC || op == T_JAL);
    reads2 = (op == T_OP || op == T_STORE || op == T_BRANCH);
    return ld && rd != 0 &&
           ((reads1 && ins[19:15] == rd) || (reads2 && ins[24:20] == rd));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [8];
    logic [31:0] w;
    ops = '{T_OP, T_STORE, T_BRANCH, T_LUI, T_AUIPC, T_JAL, T_OPIMM, T_LOAD};
    w = $urandom;
    w[6:0]   = ops[$urandom_range(0, 7)];
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  // One clock cycle: drive on the falling edge, check just after, then
  // advance the model by the rising edge that follows.
  task automatic step(input bit v, input logic [31:0] ins, input bit dr,
                      input bit fl, input bit ld, input logic [4:0] rd);
    bit hz, e_rdy, e_dv, e_st;
    @(negedge clk);
    if_valid = v; if_instr = ins; if_pc = next_pc;
    dec_ready = dr; flush = fl; ex_is_load = ld; ex_rd = rd;
    #1;
    hz    = (mq.size() > 0) && ref_hazard(mq[0][31:0], ld, rd);
    e_rdy = (mq.size() < DEPTH) && (mst != M_FLUSH);
    e_dv  = (mq.size() > 0) && (mst == M_RUN) && !hz;
    e_st  = (mst == M_STALL);
    check("if_ready", if_ready, e_rdy);
    check("dec_valid", dec_valid, e_dv);
    check("stall", stall, e_st);
    if (e_dv) begin
      check("dec_instr", dec_instr, mq[0][31:0]);
      check("dec_pc", dec_pc, mq[0][63:32]);
    end
`ifdef DECODE_PERF_CNT_EN
    check("stall_cnt", stall_cnt, m_stall_cnt);
    check("flush_cnt", flush_cnt, m_flush_cnt);
`endif
    if (e_st) m_stall_cnt++;
    if (fl)   m_flush_cnt++;
    if (fl) begin
      mq.delete();
      mst = M_FLUSH;
      if (v) next_pc += 4;  // dropped beat keeps a unique PC
    end else begin
      if (e_dv && dr) void'(mq.pop_front());
      if (v && e_rdy) begin
        mq.push_back({next_pc, ins});
        next_pc += 4;
      end
      mst = (mst == M_FLUSH) ? M_RUN : (hz ? M_STALL : M_RUN);
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("rst_dec_valid", dec_valid, 0);
    check("rst_stall", stall, 0);
    check("rst_dec_instr", dec_instr, 0);
    check("rst_dec_pc", dec_pc, 0);
`ifdef DECODE_PERF_CNT_EN
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);
`endif
    mq.delete();
    mst = M_RUN;
    m_stall_cnt = '0;
    m_flush_cnt = '0;
    @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 32'h0, 1, 0, 0, 5'd0);
  endtask

  initial begin
    #1 rstn = 1'b0;
    #1;
    check("rst_dec_valid0", dec_valid, 0);
    check("rst_stall0", stall, 0);
    check("rst_dec_pc0", dec_pc, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Streaming: PCs 0,4,8,C, first one cycle after acceptance, no bubbles.
    next_pc = '0;
    step(1, rand_instr(), 1, 0, 0, 5'd0);
    check("stream_first_dv", dec_valid, 0);
    for (int k = 0; k < 4; k++) begin
      step(k < 3, rand_instr(), 1, 0, 0, 5'd0);
      check("stream_dv", dec_valid, 1);
      check("stream_pc", dec_pc, 64'(k * 4));
    end
    idle(2);

    // Backpressure: two accepted, third held until one cycle after first pop.
    step(1, rand_instr(), 0, 0, 0, 5'd0);
    step(1, rand_instr(), 0, 0, 0, 5'd0);
    step(1, rand_instr(), 0, 0, 0, 5'd0);
    check("bp_ready_full", if_ready, 0);
    check("bp_head_stable", dec_pc, 64'h10);
    step(1, if_instr, 1, 0, 0, 5'd0);
    check("bp_ready_at_pop", if_ready, 0);
    step(1, if_instr, 1, 0, 0, 5'd0);
    check("bp_ready_after_pop", if_ready, 1);
    idle(3);

    // Load-use on add x1,x5,x2 with a load to x5 in execute.
    step(1, 32'h002280B3, 0, 0, 1, 5'd5);
    step(0, 32'h0, 1, 0, 1, 5'd5);
    check("lu_dv_hazard", dec_valid, 0);
    step(0, 32'h0, 1, 0, 1, 5'd5);
    check("lu_stall", stall, 1);
    check("lu_dv_stall", dec_valid, 0);
    step(0, 32'h0, 1, 0, 0, 5'd0);
    check("lu_dv_leaving", dec_valid, 0);
    step(0, 32'h0, 1, 0, 0, 5'd0);
    check("lu_dv_resume", dec_valid, 1);
    // lui x5 with 5 in its rs1 bit positions: no hazard.
    step(1, 32'h000282B7, 0, 0, 1, 5'd5);
    step(0, 32'h0, 0, 0, 1, 5'd5);
    check("lui_dv", dec_valid, 1);
    check("lui_stall", stall, 0);
    step(0, 32'h0, 1, 0, 1, 5'd5);
    idle(2);

    // Flush with a full buffer and a same-cycle fetch beat.
    step(1, rand_instr(), 0, 0, 0, 5'd0);
    step(1, rand_instr(), 0, 0, 0, 5'd0);
    step(1, rand_instr(), 1, 1, 0, 5'd0);
    step(0, 32'h0, 1, 0, 0, 5'd0);
    check("fl_ready_flush", if_ready, 0);
    check("fl_dv_flush", dec_valid, 0);
    step(1, rand_instr(), 1, 0, 0, 5'd0);
    check("fl_ready_after", if_ready, 1);
    check("fl_dv_empty", dec_valid, 0);
    idle(3);

    // Asynchronous reset with two entries buffered.
    step(1, rand_instr(), 0, 0, 0, 5'd0);
    step(1, rand_instr(), 0, 0, 0, 5'd0);
    async_reset();
    step(0, 32'h0, 1, 0, 0, 5'd0);
    check("rst_ready_after", if_ready, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) async_reset();
      else step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
                $urandom_range(0, 24) == 0, $urandom_range(0, 2) == 0,
                5'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
